// File: rtl/fe_pow_if.sv
// Request/response bundle for fe_pow: start/operands in, busy/done/result out,
// plus the operand/product lanes of the shared pipelined field multiplier.
interface fe_pow_if;
  logic         start;
  logic [254:0] base;
  logic [254:0] exp;
  logic         busy;
  logic         done;
  logic [254:0] result;
  logic [255:0] mul_a;
  logic [255:0] mul_b;
  logic [254:0] mul_p;
  logic [2:0]   dbg_state;

  // Handshake: start is a request that is taken only when busy is low (FSM in
  // IDLE); base/exp are sampled in that cycle. done is a one-cycle response
  // pulse with busy already low, so start in the done cycle is taken.
  modport master (
    output start, base, exp, mul_p,
    input  busy, done, result, mul_a, mul_b, dbg_state
  );

  modport slave (
    input  start, base, exp, mul_p,
    output busy, done, result, mul_a, mul_b, dbg_state
  );
endinterface

// File: rtl/fe_pow.sv
// Left-to-right square-and-multiply exponentiation in GF(2^255-19) over an
// external pipelined multiplier. Optional macro FE_POW_CANON_EN: canonical result.
module fe_pow #(
  parameter int MUL_LAT = 7
) (
  input  logic     clk,
  input  logic     rst,
  fe_pow_if.slave  bus
);

  localparam int CW = $clog2(MUL_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_SQ    = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;

  localparam logic [254:0] P = {{247{1'b1}}, 8'hED};

  logic [2:0]   state_q, state_d;
  logic [7:0]   i_q, i_d;
  logic         seen_one_q, seen_one_d;
  logic [254:0] acc_q, acc_d;
  logic [254:0] base_q, base_d;
  logic [254:0] exp_q, exp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [254:0] result_q, result_d;
  logic         done_q, done_d;

  logic         bit_cur;
  logic         last_bit;
  logic         cap;
  logic [2:0]   adv_state;
  logic [7:0]   adv_i;
  logic [254:0] canon;

  assign bit_cur  = exp_q[i_q];
  assign last_bit = (i_q == 8'd0);
  assign cap      = (cnt_q == CW'(MUL_LAT));

  // Moving past the current exponent bit: next bit, or finish after bit 0.
  assign adv_state = last_bit ? S_FINAL : S_SCAN;
  assign adv_i     = last_bit ? i_q : 8'(i_q - 8'd1);

`ifdef FE_POW_CANON_EN
  assign canon = (acc_q >= P) ? 255'(acc_q - P) : acc_q;
`else
  assign canon = acc_q;
`endif

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    seen_one_d = seen_one_q;
    acc_d      = acc_q;
    base_d     = base_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d     = bus.base;
          exp_d      = bus.exp;
          i_d        = 8'd254;
          seen_one_d = 1'b0;
          acc_d      = 255'd1;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (seen_one_q) begin
          // The squaring always precedes any multiply for this bit.
          cnt_d   = '0;
          state_d = S_SQ;
        end else begin
          if (bit_cur) begin
            acc_d      = base_q;
            seen_one_d = 1'b1;
          end
          state_d = adv_state;
          i_d     = adv_i;
        end
      end
      S_SQ: begin
        if (cap) begin
          acc_d = bus.mul_p;
          cnt_d = '0;
          if (bit_cur) begin
            state_d = S_MUL;
          end else begin
            state_d = adv_state;
            i_d     = adv_i;
          end
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      S_MUL: begin
        if (cap) begin
          acc_d   = bus.mul_p;
          cnt_d   = '0;
          state_d = adv_state;
          i_d     = adv_i;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      S_FINAL: begin
        result_d = canon;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      i_q        <= 8'd0;
      seen_one_q <= 1'b0;
      acc_q      <= 255'd1;
      base_q     <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      seen_one_q <= seen_one_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  // Operands are driven only during an op and stay put until the capture cycle,
  // so any product still in the multiplier pipeline elsewhere is never taken.
  assign bus.mul_a = (state_q == S_SQ || state_q == S_MUL) ? {1'b0, acc_q} : 256'd0;
  assign bus.mul_b = (state_q == S_SQ)  ? {1'b0, acc_q}  :
                     (state_q == S_MUL) ? {1'b0, base_q} : 256'd0;

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fe_pow.sv
// Directed bench for fe_pow with a behavioural 7-stage field multiplier and a
// scoreboard of expected result / latency / multiplier-activity per operation.
module tb_fe_pow;

  localparam int MUL_LAT = 7;
  localparam logic [254:0] P = {{247{1'b1}}, 8'hED};

  typedef struct packed {
    logic [254:0] res;
    int unsigned  lat;
    int unsigned  start_cyc;
    int unsigned  ops;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned cyc;
  int checks;
  int failures;
  int unsigned mul_cycles;
  exp_t exp_q[$];
  logic [254:0] pipe[MUL_LAT];

  fe_pow_if bus();

  fe_pow #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier model ----------------
  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t;
    t = {257'd0, a} * {257'd0, b};
    t = {257'd0, t[254:0]} + (t >> 255) * 512'd19;
    t = {257'd0, t[254:0]} + (t >> 255) * 512'd19;
    while (t >= {257'd0, P}) t = t - {257'd0, P};
    return t[254:0];
  endfunction

  always @(posedge clk) begin
    pipe[0] <= mulmod(bus.mul_a[254:0], bus.mul_b[254:0]);
    for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign bus.mul_p = pipe[MUL_LAT-1];

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!bus.busy && !bus.done) mul_cycles = 0;
      if (bus.mul_a != 256'd0 || bus.mul_b != 256'd0) mul_cycles++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 256'd1, 256'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {1'b0, bus.result}, {1'b0, e.res});
          chk("latency", 256'(cyc - e.start_cyc), 256'(e.lat));
          chk("busy_at_done", {255'd0, bus.busy}, 256'd0);
          if (e.ops != 32'hFFFF_FFFF)
            chk("mul_active_cycles", 256'(mul_cycles), 256'(e.ops));
        end
        mul_cycles = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [254:0] b, input logic [254:0] e,
                       input logic [254:0] res, input int unsigned lat, input int unsigned ops);
    exp_t x;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = b;
    bus.exp   = e;
    x.res = res; x.lat = lat; x.start_cyc = cyc; x.ops = ops;
    exp_q.push_back(x);
    @(negedge clk);
    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    chk("busy_after_start", {255'd0, bus.busy}, 256'd1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 256'(exp_q.size()), 256'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_t x;
    logic [254:0] pm2;
    logic [254:0] inv2;
    logic [254:0] p_plus3;
    logic [254:0] all_ones;
    logic [254:0] top_bit;

    cyc = 0; checks = 0; failures = 0; mul_cycles = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.base = '0; bus.exp = '0;
    pm2      = P - 255'd2;
    inv2     = (255'd1 << 254) - 255'd9;
    p_plus3  = P + 255'd3;
    all_ones = {255{1'b1}};
    top_bit  = 255'd1 << 254;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   {255'd0, bus.busy}, 256'd0);
    chk("rst_done",   {255'd0, bus.done}, 256'd0);
    chk("rst_result", {1'b0, bus.result}, 256'd0);
    chk("rst_mul_a",  bus.mul_a, 256'd0);
    chk("rst_mul_b",  bus.mul_b, 256'd0);
    rst = 1'b0;

    issue(255'd7, 255'd0, 255'd1, 257, 0);
    drain(400);
    issue(255'd3, 255'd3, 255'd27, 273, 16);
    drain(400);
    issue(255'd2, pm2, inv2, 4305, 4048);
    drain(5000);
    chk("inverse_times_two", {1'b0, mulmod(bus.result, 255'd2)}, 256'd1);
`ifdef FE_POW_CANON_EN
    issue(p_plus3, 255'd1, 255'd3, 257, 0);
    drain(400);
    issue(P, 255'd1, 255'd0, 257, 0);
    drain(400);
`else
    issue(p_plus3, 255'd1, p_plus3, 257, 0);
    drain(400);
    issue(P, 255'd1, P, 257, 0);
    drain(400);
`endif
    issue(255'd0, 255'd5, 255'd0, 281, 32'hFFFF_FFFF);
    drain(400);
    issue(255'd3, 255'd10, 255'd59049, 289, 32);
    drain(400);
    issue(all_ones, 255'd2, 255'd324, 265, 8);
    drain(400);
    issue(255'd1, top_bit, 255'd1, 2289, 2032);
    drain(2600);

    // start held high through the whole operation with junk operands, then a
    // fresh request lands exactly in the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.base = 255'd3; bus.exp = 255'd3;
    x.res = 255'd27; x.lat = 273; x.start_cyc = cyc; x.ops = 16;
    exp_q.push_back(x);
    repeat (272) begin
      @(negedge clk);
      bus.start = 1'b1; bus.base = 255'd9; bus.exp = 255'd5;
    end
    @(negedge clk);
    bus.start = 1'b1; bus.base = 255'd7; bus.exp = 255'd0;
    x.res = 255'd1; x.lat = 257; x.start_cyc = cyc; x.ops = 0;
    exp_q.push_back(x);
    @(negedge clk);
    bus.start = 1'b0; bus.base = '0; bus.exp = '0;
    drain(400);

    // Abort an inversion at cycle 100 with a one-cycle reset.
    issue(255'd2, pm2, inv2, 4305, 4048);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_busy",   {255'd0, bus.busy}, 256'd0);
    chk("abort_done",   {255'd0, bus.done}, 256'd0);
    chk("abort_result", {1'b0, bus.result}, 256'd0);
    rst = 1'b0;
    issue(255'd5, 255'd2, 255'd25, 265, 8);
    drain(400);

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
